// File: rtl/ps2_key_decoder_if.sv
// Interface: ps2_key_decoder_if
// Raw PS/2 lines from the keyboard plus the decoded key outputs.
// The decoder takes the slave modport; the keyboard side and the
// key consumer take the master modport.
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key;
    logic       key_ext;
    logic       new_code;
    logic       frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  key,
        input  key_ext,
        input  new_code,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output key,
        output key_ext,
        output new_code,
        output frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// Module: ps2_key_decoder
// Receives PS/2 keyboard frames, checks start/parity/stop, tracks the
// E0 (extended) and F0 (break) prefixes, and presents the currently held
// key. key = 8'h00 means no key is held.
// Optional feature: define PS2_WATCHDOG_EN to add an idle watchdog that
// aborts a frame when ps2_clk stops toggling for TIMEOUT_CYC clk cycles.
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8
`ifdef PS2_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYC = 50000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    ps2_key_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_STOP  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BREAK = 8'hF0;

    // Odd parity over data plus parity bit: the XOR of all nine bits is 1.
    function automatic logic odd_parity_ok(input logic [8:0] v);
        return ^v;
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic             r_clk_meta;
    logic             r_clk_sync;
    logic             r_dat_meta;
    logic             r_dat_sync;
    logic             r_filt_clk;
    logic [FCW-1:0]   r_filt_cnt;
    logic             r_fall;
    logic [8:0]       r_shift;
    logic [3:0]       r_bit_cnt;
    logic             r_break_pend;
    logic             r_ext_pend;
    logic [7:0]       r_key;
    logic             r_key_ext;
    logic             r_new_code;
    logic             r_frame_err;
    logic             w_shift_en;
    logic             w_cnt_clr;
    logic             w_err;
    logic             w_wd_expire;
    logic [7:0]       w_code;

    assign w_code = r_shift[7:0];

    // Two-flop synchronisers; idle PS/2 lines are high, so reset to 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= bus.ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= bus.ps2_data;
            r_dat_sync <= r_dat_meta;
        end
    end

    // Glitch filter on ps2_clk; r_fall strobes one cycle on an accepted 1->0 change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_clk_sync == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FCW'(FILTER_LEN - 1)) begin
                r_filt_clk <= r_clk_sync;
                r_filt_cnt <= '0;
                r_fall     <= r_filt_clk;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

`ifdef PS2_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    logic [WDW-1:0] r_wd_cnt;

    assign w_wd_expire = ((r_state == ST_RECV) || (r_state == ST_STOP)) && !r_fall &&
                         (r_wd_cnt == WDW'(TIMEOUT_CYC - 1));

    // Idle counter: runs mid-frame, cleared by every falling edge or outside a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd_cnt <= '0;
        end else if (r_fall || w_wd_expire ||
                     !((r_state == ST_RECV) || (r_state == ST_STOP))) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end
`else
    assign w_wd_expire = 1'b0;
`endif

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Frame FSM next-state and datapath strobes.
    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        w_cnt_clr    = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_clr = 1'b1;
                if (r_fall && !r_dat_sync) begin
                    w_next_state = ST_RECV;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (w_wd_expire) begin
                    w_err        = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (r_fall) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 4'd8) begin
                        w_cnt_clr    = 1'b1;
                        w_next_state = ST_STOP;
                    end else begin
                        w_next_state = ST_RECV;
                    end
                end else begin
                    w_next_state = ST_RECV;
                end
            end
            ST_STOP: begin
                if (w_wd_expire) begin
                    w_err        = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (r_fall) begin
                    if (r_dat_sync && odd_parity_ok(r_shift)) begin
                        w_next_state = ST_CHECK;
                    end else begin
                        w_err        = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_next_state = ST_STOP;
                end
            end
            ST_CHECK: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_cnt_clr    = 1'b1;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Shift register (LSB first) and bit counter for d0..d7 and parity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift   <= 9'd0;
            r_bit_cnt <= 4'd0;
        end else begin
            if (w_shift_en) begin
                r_shift <= {r_dat_sync, r_shift[8:1]};
            end else begin
                r_shift <= r_shift;
            end
            if (w_cnt_clr) begin
                r_bit_cnt <= 4'd0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
        end
    end

    // Key tracking: prefixes set pending flags, the final code makes or breaks the key.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key        <= 8'h00;
            r_key_ext    <= 1'b0;
            r_break_pend <= 1'b0;
            r_ext_pend   <= 1'b0;
            r_new_code   <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_new_code  <= 1'b0;
            r_frame_err <= w_err;
            if (r_state == ST_CHECK) begin
                if (w_code == CODE_EXT) begin
                    r_ext_pend <= 1'b1;
                end else if (w_code == CODE_BREAK) begin
                    r_break_pend <= 1'b1;
                end else if (r_break_pend) begin
                    // Only a break matching both code and extension releases the key.
                    if ((w_code == r_key) && (r_ext_pend == r_key_ext)) begin
                        r_key     <= 8'h00;
                        r_key_ext <= 1'b0;
                    end else begin
                        r_key     <= r_key;
                        r_key_ext <= r_key_ext;
                    end
                    r_break_pend <= 1'b0;
                    r_ext_pend   <= 1'b0;
                end else begin
                    r_key      <= w_code;
                    r_key_ext  <= r_ext_pend;
                    r_ext_pend <= 1'b0;
                    r_new_code <= 1'b1;
                end
            end else begin
                r_key <= r_key;
            end
        end
    end

    assign bus.key       = r_key;
    assign bus.key_ext   = r_key_ext;
    assign bus.new_code  = r_new_code;
    assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench: tb_ps2_key_decoder
// Directed PS/2 frames with hand-computed expected key state.
// Define PS2_WATCHDOG_EN to also exercise the idle watchdog (TIMEOUT_CYC=1000).
module tb_ps2_key_decoder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   nc_cnt = 0;
    int   fe_cnt = 0;

    ps2_key_decoder_if bus();

`ifdef PS2_WATCHDOG_EN
    ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(1000)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    ps2_key_decoder #(.FILTER_LEN(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    // Count clk cycles on which each pulse output is high.
    always @(posedge clk) begin
        if (bus.new_code === 1'b1) nc_cnt <= nc_cnt + 1;
        if (bus.frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    end

    task automatic send_bit(input logic b);
        bus.ps2_data = b;
        repeat (10) @(posedge clk);
        bus.ps2_clk = 1'b0;
        repeat (20) @(posedge clk);
        bus.ps2_clk = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        logic par;
        par = (~^d) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(~bad_stop);
        repeat (5) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.key !== 8'h00) begin errors++; $display("FAIL reset_key got %h exp 00", bus.key); end
        checks++; if (bus.key_ext !== 1'b0) begin errors++; $display("FAIL reset_ext got %b exp 0", bus.key_ext); end
        checks++; if (bus.new_code !== 1'b0) begin errors++; $display("FAIL reset_nc got %b exp 0", bus.new_code); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe got %b exp 0", bus.frame_err); end
        rst = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_make();
        int nc0, fe0;
        nc0 = nc_cnt; fe0 = fe_cnt;
        send_frame(8'h23, 1'b0, 1'b0);
        checks++; if (bus.key !== 8'h23) begin errors++; $display("FAIL make_key got %h exp 23", bus.key); end
        checks++; if (bus.key_ext !== 1'b0) begin errors++; $display("FAIL make_ext got %b exp 0", bus.key_ext); end
        checks++; if (nc_cnt - nc0 !== 1) begin errors++; $display("FAIL make_nc got %0d exp 1", nc_cnt - nc0); end
        checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL make_fe got %0d exp 0", fe_cnt - fe0); end
    endtask

    task automatic test_break();
        int nc0;
        nc0 = nc_cnt;
        send_frame(8'hF0, 1'b0, 1'b0);
        checks++; if (bus.key !== 8'h23) begin errors++; $display("FAIL break_prefix_key got %h exp 23", bus.key); end
        send_frame(8'h23, 1'b0, 1'b0);
        checks++; if (bus.key !== 8'h00) begin errors++; $display("FAIL break_key got %h exp 00", bus.key); end
        checks++; if (nc_cnt - nc0 !== 0) begin errors++; $display("FAIL break_nc got %0d exp 0", nc_cnt - nc0); end
    endtask

    task automatic test_ext();
        int nc0;
        nc0 = nc_cnt;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        checks++; if (bus.key !== 8'h75) begin errors++; $display("FAIL ext_key got %h exp 75", bus.key); end
        checks++; if (bus.key_ext !== 1'b1) begin errors++; $display("FAIL ext_flag got %b exp 1", bus.key_ext); end
        checks++; if (nc_cnt - nc0 !== 1) begin errors++; $display("FAIL ext_nc got %0d exp 1", nc_cnt - nc0); end
        nc0 = nc_cnt;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        checks++; if (bus.key !== 8'h00) begin errors++; $display("FAIL ext_break_key got %h exp 00", bus.key); end
        checks++; if (bus.key_ext !== 1'b0) begin errors++; $display("FAIL ext_break_flag got %b exp 0", bus.key_ext); end
        checks++; if (nc_cnt - nc0 !== 0) begin errors++; $display("FAIL ext_break_nc got %0d exp 0", nc_cnt - nc0); end
    endtask

    task automatic test_frame_errors();
        int nc0, fe0;
        send_frame(8'h23, 1'b0, 1'b0);
        nc0 = nc_cnt; fe0 = fe_cnt;
        send_frame(8'h1C, 1'b1, 1'b0);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL parity_fe got %0d exp 1", fe_cnt - fe0); end
        checks++; if (nc_cnt - nc0 !== 0) begin errors++; $display("FAIL parity_nc got %0d exp 0", nc_cnt - nc0); end
        checks++; if (bus.key !== 8'h23) begin errors++; $display("FAIL parity_key got %h exp 23", bus.key); end
        fe0 = fe_cnt;
        send_frame(8'h1C, 1'b0, 1'b1);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL stop_fe got %0d exp 1", fe_cnt - fe0); end
        checks++; if (bus.key !== 8'h23) begin errors++; $display("FAIL stop_key got %h exp 23", bus.key); end
    endtask

    task automatic test_back_to_back();
        int nc0;
        nc0 = nc_cnt;
        send_frame(8'h23, 1'b0, 1'b0);
        checks++; if (nc_cnt - nc0 !== 1) begin errors++; $display("FAIL repeat_nc got %0d exp 1", nc_cnt - nc0); end
        checks++; if (bus.key !== 8'h23) begin errors++; $display("FAIL repeat_key got %h exp 23", bus.key); end
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        checks++; if (bus.key !== 8'h23) begin errors++; $display("FAIL other_break_key got %h exp 23", bus.key); end
        send_frame(8'h1C, 1'b0, 1'b0);
        checks++; if (bus.key !== 8'h1C) begin errors++; $display("FAIL last_wins_key got %h exp 1C", bus.key); end
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h23, 1'b0, 1'b0);
        checks++; if (bus.key !== 8'h1C) begin errors++; $display("FAIL old_break_key got %h exp 1C", bus.key); end
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        checks++; if (bus.key !== 8'h1C) begin errors++; $display("FAIL ext_mismatch_key got %h exp 1C", bus.key); end
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        checks++; if (bus.key !== 8'h00) begin errors++; $display("FAIL release_key got %h exp 00", bus.key); end
    endtask

    task automatic test_glitch_reset();
        int nc0, fe0;
        nc0 = nc_cnt; fe0 = fe_cnt;
        bus.ps2_data = 1'b0;
        repeat (10) @(posedge clk);
        bus.ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        bus.ps2_clk = 1'b1;
        repeat (30) @(posedge clk);
        bus.ps2_data = 1'b1;
        @(negedge clk);
        checks++; if (nc_cnt - nc0 !== 0 || fe_cnt - fe0 !== 0) begin
            errors++; $display("FAIL glitch_pulses got nc %0d fe %0d exp 0 0", nc_cnt - nc0, fe_cnt - fe0);
        end
        send_frame(8'h1D, 1'b0, 1'b0);
        checks++; if (bus.key !== 8'h1D) begin errors++; $display("FAIL glitch_next_key got %h exp 1D", bus.key); end
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1 & (8'h1B >> i));
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.key !== 8'h00 || bus.key_ext !== 1'b0 || bus.new_code !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++; $display("FAIL midframe_rst got key %h ext %b nc %b fe %b exp 00 0 0 0",
                               bus.key, bus.key_ext, bus.new_code, bus.frame_err);
        end
        rst = 1'b1;
        repeat (20) @(posedge clk);
        nc0 = nc_cnt;
        send_frame(8'h1B, 1'b0, 1'b0);
        checks++; if (bus.key !== 8'h1B) begin errors++; $display("FAIL after_rst_key got %h exp 1B", bus.key); end
        checks++; if (nc_cnt - nc0 !== 1) begin errors++; $display("FAIL after_rst_nc got %0d exp 1", nc_cnt - nc0); end
    endtask

`ifdef PS2_WATCHDOG_EN
    task automatic test_watchdog();
        int fe0;
        fe0 = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1 & (8'h1B >> i));
        repeat (900) @(posedge clk);
        @(negedge clk);
        checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL wd_early got %0d exp 0", fe_cnt - fe0); end
        repeat (200) @(posedge clk);
        @(negedge clk);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL wd_abort got %0d exp 1", fe_cnt - fe0); end
        send_frame(8'h1D, 1'b0, 1'b0);
        checks++; if (bus.key !== 8'h1D) begin errors++; $display("FAIL wd_next_key got %h exp 1D", bus.key); end
    endtask
`endif

    initial begin
        test_reset();
        test_make();
        test_break();
        test_ext();
        test_frame_errors();
        test_back_to_back();
        test_glitch_reset();
`ifdef PS2_WATCHDOG_EN
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
